du_dump_sequencer: RTL

DU_DUMP_SEQUENCER -- requirements
Module: du_dump_sequencer

---
 rtl/du_dump_sequencer_pkg.sv | 29 ++
 rtl/du_dump_sequencer_if.sv | 23 ++
 rtl/du_byte_serializer.sv | 35 +++
 rtl/du_dump_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/du_dump_sequencer_pkg.sv
// Shared constants for the debug-unit dump sequencer: state encoding, register count and byte budgets.
package du_dump_sequencer_pkg;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_SNAP     = 4'd1;
    localparam logic [3:0] ST_LAT_SEND = 4'd2;
    localparam logic [3:0] ST_REG_ADDR = 4'd3;
    localparam logic [3:0] ST_REG_WAIT = 4'd4;
    localparam logic [3:0] ST_REG_SEND = 4'd5;
    localparam logic [3:0] ST_MEM_ADDR = 4'd6;
    localparam logic [3:0] ST_MEM_WAIT = 4'd7;
    localparam logic [3:0] ST_MEM_SEND = 4'd8;
    localparam logic [3:0] ST_DONE     = 4'd9;

    localparam int N_REGS     = 32;
    localparam int WORD_BYTES = 4;

    function automatic int latBytes(input int nbRInt);
        return (nbRInt + 7) / 8;
    endfunction

    function automatic int dumpBytes(input int nbRInt, input int nMemWords);
        return latBytes(nbRInt) + WORD_BYTES * N_REGS + WORD_BYTES * nMemWords;
    endfunction

    localparam int LAT_BYTES  = latBytes(341);
    localparam int DUMP_BYTES = dumpBytes(341, 64);

endpackage

// File: rtl/du_dump_sequencer_if.sv
// Read-port and UART-TX handshake bundle between the dump sequencer and its environment.
interface du_dump_sequencer_if #(
    parameter int NB_REG = 32
);
    logic [4:0]        o_reg_addr;
    logic [7:0]        o_mem_addr;
    logic              o_read_en;
    logic [NB_REG-1:0] i_reg_data;
    logic [NB_REG-1:0] i_mem_data;
    logic [7:0]        o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready;

    modport master (
        output o_reg_addr, o_mem_addr, o_read_en, o_tx_data, o_tx_valid,
        input  i_reg_data, i_mem_data, i_tx_ready
    );

    modport slave (
        input  o_reg_addr, o_mem_addr, o_read_en, o_tx_data, o_tx_valid,
        output i_reg_data, i_mem_data, i_tx_ready
    );
endinterface

// File: rtl/du_byte_serializer.sv
// Emits bytes 0..i_lastIdx of i_data LSB first over a valid/ready handshake.
module du_byte_serializer #(
    parameter int DW    = 344,
    parameter int IDX_W = $clog2(DW / 8)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [DW-1:0]    i_data,
    input  logic [IDX_W-1:0] i_lastIdx,
    input  logic             i_tx_ready,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    output logic             o_lastFire
);
    logic [IDX_W-1:0] r_byteIdx;
    logic             w_fire;
    logic             w_last;

    assign w_fire = i_valid && i_tx_ready;
    assign w_last = (r_byteIdx == i_lastIdx);

    // Index only moves on a completed transfer, so the presented byte is held through stalls.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_byteIdx <= '0;
        end else if (w_fire) begin
            r_byteIdx <= w_last ? '0 : r_byteIdx + 1'b1;
        end
    end

    assign o_tx_valid = i_valid;
    assign o_tx_data  = i_valid ? i_data[{r_byteIdx, 3'b000} +: 8] : 8'h00;
    assign o_lastFire = w_fire && w_last;
endmodule

// File: rtl/du_dump_sequencer.sv
// Dumps a pipeline-latch snapshot, the register file and N_MEM_WORDS data-memory words as a byte stream.
module du_dump_sequencer
    import du_dump_sequencer_pkg::*;
#(
    parameter int NB_REG      = 32,
    parameter int NB_R_INT    = 341,
    parameter int N_MEM_WORDS = 64
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_R_INT-1:0] i_latches,
    du_dump_sequencer_if.master io_bus,
    output logic                o_busy,
    output logic                o_done
);
    localparam int LAT_B = latBytes(NB_R_INT);
    localparam int SER_W = (LAT_B * 8 > 32) ? LAT_B * 8 : 32;
    localparam int IDX_W = $clog2(SER_W / 8);
    localparam logic [IDX_W-1:0] LAT_LAST  = IDX_W'(LAT_B - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORD_BYTES - 1);
    localparam logic [4:0]       REG_LAST  = 5'(N_REGS - 1);
    localparam logic [7:0]       MEM_LAST  = 8'(N_MEM_WORDS - 1);

    logic [3:0]       r_state;
    logic [4:0]       r_regIdx;
    logic [7:0]       r_memIdx;
    logic [SER_W-1:0] r_snap;
    logic [31:0]      r_word;

    logic             w_serValid;
    logic [SER_W-1:0] w_serData;
    logic [IDX_W-1:0] w_serLast;
    logic             w_lastFire;

    always_comb begin
        w_serValid = (r_state == ST_LAT_SEND) || (r_state == ST_REG_SEND) || (r_state == ST_MEM_SEND);
        w_serData  = (r_state == ST_LAT_SEND) ? r_snap : SER_W'(r_word);
        w_serLast  = (r_state == ST_LAT_SEND) ? LAT_LAST : WORD_LAST;
    end

    du_byte_serializer #(
        .DW    (SER_W),
        .IDX_W (IDX_W)
    ) u_serializer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (w_serValid),
        .i_data     (w_serData),
        .i_lastIdx  (w_serLast),
        .i_tx_ready (io_bus.i_tx_ready),
        .o_tx_data  (io_bus.o_tx_data),
        .o_tx_valid (io_bus.o_tx_valid),
        .o_lastFire (w_lastFire)
    );

    // Indices stop at their terminal value; the phase change, not a wrap, ends each read loop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_regIdx <= '0;
            r_memIdx <= '0;
            r_snap   <= '0;
            r_word   <= '0;
        end else begin
            case (r_state)
                ST_IDLE:     if (i_start) r_state <= ST_SNAP;
                ST_SNAP: begin
                    r_snap   <= SER_W'(i_latches);
                    r_regIdx <= '0;
                    r_memIdx <= '0;
                    r_state  <= ST_LAT_SEND;
                end
                ST_LAT_SEND: if (w_lastFire) r_state <= ST_REG_ADDR;
                ST_REG_ADDR: r_state <= ST_REG_WAIT;
                ST_REG_WAIT: begin
                    r_word  <= 32'(io_bus.i_reg_data);
                    r_state <= ST_REG_SEND;
                end
                ST_REG_SEND: if (w_lastFire) begin
                    if (r_regIdx == REG_LAST) begin
                        r_state <= ST_MEM_ADDR;
                    end else begin
                        r_regIdx <= r_regIdx + 5'd1;
                        r_state  <= ST_REG_ADDR;
                    end
                end
                ST_MEM_ADDR: r_state <= ST_MEM_WAIT;
                ST_MEM_WAIT: begin
                    r_word  <= 32'(io_bus.i_mem_data);
                    r_state <= ST_MEM_SEND;
                end
                ST_MEM_SEND: if (w_lastFire) begin
                    if (r_memIdx == MEM_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_memIdx <= r_memIdx + 8'd1;
                        r_state  <= ST_MEM_ADDR;
                    end
                end
                ST_DONE:     r_state <= ST_IDLE;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.o_reg_addr = r_regIdx;
    assign io_bus.o_mem_addr = r_memIdx;
    assign io_bus.o_read_en  = (r_state == ST_REG_ADDR) || (r_state == ST_MEM_ADDR);
    assign o_busy            = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_done            = (r_state == ST_DONE);
endmodule
